// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder with valid/ready flow control.
//
// Stage 1 registers bit propagate/generate and 4-bit group propagate/generate.
// Stage 2 resolves group carries by lookahead over clusters of 4 groups (clusters
// chained), then in-group carries by 4-bit lookahead, and registers the result.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (in_ready is combinational, independent of in_valid)
//   a, b, cin          operands and carry in
//   sub                (only with CLA_PIPE_SUB_EN) 1 = compute a - b
//   out_valid/out_ready result handshake
//   sum, cout, ovf     result, carry out of MSB, two's-complement overflow
//   gp, gg             whole-word propagate / generate (gg independent of cin)
//
// Optional feature macro: CLA_PIPE_SUB_EN (adds the sub port).

module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef CLA_PIPE_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             gp,
  output logic             gg
);

  localparam int NGRP = int'(WIDTH / 4);
  localparam int NCLU = (NGRP + 3) / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_chk
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 in 4..64");
  end

  // Stage 1 operand conditioning
  logic [WIDTH-1:0] w_b;
  logic             w_cin;
`ifdef CLA_PIPE_SUB_EN
  assign w_b   = sub ? ~b : b;
  assign w_cin = sub | cin;  // subtraction forces carry-in = 1
`else
  assign w_b   = b;
  assign w_cin = cin;
`endif

  logic [WIDTH-1:0] w_p, w_g;
  logic [NGRP-1:0]  w_grp_p, w_grp_g;

  assign w_p = a ^ w_b;
  assign w_g = a & w_b;

  always_comb begin
    w_grp_p = '0;
    w_grp_g = '0;
    for (int j = 0; j < NGRP; j++) begin
      w_grp_p[j] = &w_p[4*j +: 4];
      w_grp_g[j] = w_g[4*j+3]
                 | (w_p[4*j+3] & w_g[4*j+2])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                 | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
    end
  end

  // Flow control
  logic r_s1_valid, r_out_valid;
  logic w_adv2, w_acc;

  assign w_adv2   = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready = ~r_s1_valid | w_adv2;
  assign w_acc    = in_valid & in_ready;

  // Stage 1 registers
  logic [WIDTH-1:0] r_p, r_g;
  logic [NGRP-1:0]  r_grp_p, r_grp_g;
  logic             r_cin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_p        <= '0;
      r_g        <= '0;
      r_grp_p    <= '0;
      r_grp_g    <= '0;
      r_cin      <= 1'b0;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_p        <= w_p;
      r_g        <= w_g;
      r_grp_p    <= w_grp_p;
      r_grp_g    <= w_grp_g;
      r_cin      <= w_cin;
    end else if (w_adv2) begin
      r_s1_valid <= 1'b0;
    end
  end

  // Stage 2: group carries. Each group carry is a flat lookahead from its cluster's carry-in;
  // only the cluster carry-in chains between clusters.
  logic [NGRP:0] w_gc;

  always_comb begin
    logic [NGRP:0] v_gc;
    logic          v_acc, v_pp;
    v_gc    = '0;
    v_acc   = 1'b0;
    v_pp    = 1'b1;
    v_gc[0] = r_cin;
    for (int k = 0; k < NCLU; k++) begin
      for (int j = 1; j <= 4; j++) begin
        if (4*k + j <= NGRP) begin
          v_acc = 1'b0;
          v_pp  = 1'b1;
          for (int i = j - 1; i >= 0; i--) begin
            v_acc = v_acc | (v_pp & r_grp_g[4*k+i]);
            v_pp  = v_pp & r_grp_p[4*k+i];
          end
          v_gc[4*k+j] = v_acc | (v_pp & v_gc[4*k]);
        end
      end
    end
    w_gc = v_gc;
  end

  // In-group bit carries by 4-bit lookahead from each group's carry-in
  logic [WIDTH:0] w_c;

  always_comb begin
    logic [WIDTH:0] v_c;
    logic           v_acc, v_pp;
    v_c   = '0;
    v_acc = 1'b0;
    v_pp  = 1'b1;
    for (int j = 0; j < NGRP; j++) begin
      v_c[4*j] = w_gc[j];
      for (int m = 1; m <= 3; m++) begin
        v_acc = 1'b0;
        v_pp  = 1'b1;
        for (int i = m - 1; i >= 0; i--) begin
          v_acc = v_acc | (v_pp & r_g[4*j+i]);
          v_pp  = v_pp & r_p[4*j+i];
        end
        v_c[4*j+m] = v_acc | (v_pp & w_gc[j]);
      end
    end
    v_c[WIDTH] = w_gc[NGRP];
    w_c = v_c;
  end

  // Whole-word generate: group generates combined with an implicit carry-in of 0
  logic w_word_g;

  always_comb begin
    w_word_g = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      w_word_g = r_grp_g[j] | (r_grp_p[j] & w_word_g);
    end
  end

  // Stage 2 registers
  logic [WIDTH-1:0] r_sum;
  logic             r_cout, r_ovf, r_gp, r_gg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_gp        <= 1'b0;
      r_gg        <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= 1'b1;
      r_sum       <= r_p ^ w_c[WIDTH-1:0];
      r_cout      <= w_c[WIDTH];
      r_ovf       <= w_c[WIDTH] ^ w_c[WIDTH-1];
      r_gp        <= &r_p;
      r_gg        <= w_word_g;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign gp        = r_gp;
  assign gg        = r_gg;

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;

  localparam int W = 16;
  localparam int NRAND = 24;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cout, ovf, gp, gg;
`ifdef CLA_PIPE_SUB_EN
  logic         sub;
  logic         in_valid8, in_ready8, cin8, out_valid8, out_ready8, sub8;
  logic [7:0]   a8, b8, sum8;
  logic         cout8, ovf8, gp8, gg8;
`endif

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef CLA_PIPE_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .gp        (gp),
    .gg        (gg)
  );

`ifdef CLA_PIPE_SUB_EN
  cla_pipe_adder #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .sub       (sub8),
    .a         (a8),
    .b         (b8),
    .cin       (cin8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .sum       (sum8),
    .cout      (cout8),
    .ovf       (ovf8),
    .gp        (gp8),
    .gg        (gg8)
  );
`endif

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout, ovf, gp, gg;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cin, cout, ovf, gp, gg;
  } res_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the operands
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    res_t         r;
    logic [W:0]   t, t0;
    t      = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    t0     = {1'b0, x} + {1'b0, y};
    r.sum  = t[W-1:0];
    r.cin  = ci;
    r.cout = t[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    r.gp   = ((x ^ y) == {W{1'b1}});
    r.gg   = t0[W];
    return r;
  endfunction

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, "_sum"}, sum, e.sum);
    chk({tag, "_cout"}, cout, e.cout);
    chk({tag, "_ovf"}, ovf, e.ovf);
    chk({tag, "_gp"}, gp, e.gp);
    chk({tag, "_gg"}, gg, e.gg);
    chk({tag, "_cascade"}, gg | (gp & e.cin), e.cout);
  endtask

  vec_t vt[8];
  res_t q[$];
  res_t ex;
  logic pat[4];

  initial begin
    vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vt[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[7] = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CLA_PIPE_SUB_EN
    sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
`endif

    // Reset state
    #17;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, '0);
    chk("rst_flags", {cout, ovf, gp, gg}, 4'b0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    // Directed vectors, one at a time, checking 2-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = vt[i].a; b = vt[i].b; cin = vt[i].cin; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("dir%0d_lat_early", i), out_valid, 1'b0);
      step();
      chk($sformatf("dir%0d_valid", i), out_valid, 1'b1);
      ex = '{vt[i].sum, vt[i].cin, vt[i].cout, vt[i].ovf, vt[i].gp, vt[i].gg};
      chk_out($sformatf("dir%0d", i), ex);
    end
    step();

    // Reset mid-stream with two beats in flight
    out_ready = 1'b0;
    a = 16'h0101; b = 16'h0202; cin = 1'b0; in_valid = 1'b1;
    step();
    a = 16'h0303; b = 16'h0404;
    step();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1'b1);
    chk("mid_pre_full", in_ready, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_sum", sum, '0);
    step();
    #2;
    rst_n = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("mid_stale%0d", i), out_valid, 1'b0);
    end

    // Random stream with out_ready pattern 1,0,0,1
    begin
      int sent = 0;
      int got = 0;
      int cyc = 0;
      while (got < NRAND && cyc < 500) begin
        in_valid  = (sent < NRAND) && ($urandom_range(3) != 0);
        a         = W'($urandom);
        b         = W'($urandom);
        cin       = 1'($urandom_range(1));
        out_ready = pat[cyc % 4];
        #1;
        chk($sformatf("str_in_ready_c%0d", cyc), in_ready,
            !(q.size() == 2 && !out_ready));
        if (out_valid) begin
          if (q.size() == 0) begin
            chk($sformatf("str_extra_c%0d", cyc), out_valid, 1'b0);
          end else begin
            chk_out($sformatf("str%0d", got), q[0]);
            if (out_ready) begin
              void'(q.pop_front());
              got++;
            end
          end
        end
        if (in_valid && in_ready) begin
          q.push_back(model(a, b, cin));
          sent++;
        end
        step();
        cyc++;
      end
      chk("str_count", got, NRAND);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        chk($sformatf("str_drain%0d", i), out_valid, 1'b0);
      end
    end

`ifdef CLA_PIPE_SUB_EN
    // Subtraction at WIDTH=8; cin is ignored when sub=1
    a8 = 8'h05; b8 = 8'h07; cin8 = 1'b1; sub8 = 1'b1; in_valid8 = 1'b1;
    step();
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0;
    step();
    in_valid8 = 1'b0;
    chk("sub0_valid", out_valid8, 1'b1);
    chk("sub0_sum", sum8, 8'hFE);
    chk("sub0_cout", cout8, 1'b0);
    chk("sub0_ovf", ovf8, 1'b0);
    step();
    chk("sub1_valid", out_valid8, 1'b1);
    chk("sub1_sum", sum8, 8'h7F);
    chk("sub1_ovf", ovf8, 1'b1);
    chk("sub1_cout", cout8, 1'b1);
    sub8 = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
